ccc_lock_reset_ctrl: RTL

// Sequences the fabric CCC/PLL: holds PLL in reset at power-up, waits for LOCK,

---
 rtl/ccc_lock_reset_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ccc_lock_reset_ctrl.sv
// CCC/PLL lock sequencer: pulses PLL reset, qualifies LOCK, then releases a system reset.
// Optional macro CCC_LOCK_TIMEOUT_EN re-pulses the PLL reset if LOCK never arrives.
module ccc_lock_reset_ctrl #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W               = 17
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       LOCK,
    input  logic       CLR_STATUS,
    output logic       PLL_ARST_N,
    output logic       SYS_RESET_N,
    output logic       READY,
    output logic       LOCK_LOST,
    output logic [7:0] RELOCK_COUNT,
    output logic [2:0] STATE
);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_HOLD      = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_LOST      = 3'd5;

    localparam logic [CNT_W-1:0] PLL_LOAD    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic             sync1_q, lock_s_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pll_arst_n_q, pll_arst_n_d;
    logic             sys_reset_n_q, sys_reset_n_d;
    logic             lock_lost_q, lock_lost_d;
    logic [7:0]       relock_count_q, relock_count_d;
    logic             cnt_zero;
    logic             lost_entry;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        case (state_q)
            ST_PLL_RST: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = STABLE_LOAD;
                end
`ifdef CCC_LOCK_TIMEOUT_EN
                else if (cnt_zero) begin
                    state_d = ST_PLL_RST;
                    cnt_d   = PLL_LOAD;
                end
`endif
            end
            ST_STABLE: begin
                // A dropout before qualification is just a restart, not a loss event.
                if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = WAIT_LOAD;
                end else if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (!lock_s_q) begin
                    state_d = ST_LOST;
                end else if (cnt_zero) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    state_d = ST_LOST;
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = WAIT_LOAD;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = PLL_LOAD;
            end
        endcase
    end

    // Status is set on entry to LOST; a coincident clear loses to the set.
    always_comb begin
        lost_entry     = (state_d == ST_LOST) && (state_q != ST_LOST);
        lock_lost_d    = lock_lost_q;
        relock_count_d = relock_count_q;
        if (lost_entry) begin
            lock_lost_d = 1'b1;
            if (relock_count_q != 8'hff) begin
                relock_count_d = relock_count_q + 8'd1;
            end
        end else if (CLR_STATUS) begin
            lock_lost_d = 1'b0;
        end
        pll_arst_n_d  = (state_d != ST_PLL_RST);
        sys_reset_n_d = (state_d == ST_RUN);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q        <= 1'b0;
            lock_s_q       <= 1'b0;
            state_q        <= ST_PLL_RST;
            cnt_q          <= PLL_LOAD;
            pll_arst_n_q   <= 1'b0;
            sys_reset_n_q  <= 1'b0;
            lock_lost_q    <= 1'b0;
            relock_count_q <= 8'd0;
        end else begin
            sync1_q        <= LOCK;
            lock_s_q       <= sync1_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pll_arst_n_q   <= pll_arst_n_d;
            sys_reset_n_q  <= sys_reset_n_d;
            lock_lost_q    <= lock_lost_d;
            relock_count_q <= relock_count_d;
        end
    end

    assign PLL_ARST_N   = pll_arst_n_q;
    assign SYS_RESET_N  = sys_reset_n_q;
    assign READY        = sys_reset_n_q;
    assign LOCK_LOST    = lock_lost_q;
    assign RELOCK_COUNT = relock_count_q;
    assign STATE        = state_q;

endmodule
